// File: rtl/calc_determinant.sv
// SURF Hessian-determinant engine: scans every FSxFS window of an integral image,
// evaluates Dxx/Dyy/Dxy box filters and writes a clamped determinant per window.
module calc_determinant #(
    parameter int A_WIDTH   = 17,
    parameter int D_WIDTH   = 16,
    parameter int COL       = 320,
    parameter int ROW       = 240,
    parameter int FS        = 9,
    parameter int XA_WIDTH  = 4,
    parameter int XYA_WIDTH = 5,
    parameter int RD_WIDTH  = 32,
    parameter int MAXBOX    = 4,
    parameter int DET_SHIFT = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Go,
    output logic [A_WIDTH-1:0]   I_Addr,
    input  logic [D_WIDTH-1:0]   I_Data,
    output logic [XA_WIDTH-1:0]  X_Addr,
    input  logic [RD_WIDTH-1:0]  X_Data,
    output logic [XA_WIDTH-1:0]  Y_Addr,
    input  logic [RD_WIDTH-1:0]  Y_Data,
    output logic [XYA_WIDTH-1:0] XY_Addr,
    input  logic [RD_WIDTH-1:0]  XY_Data,
    output logic [A_WIDTH-1:0]   D_Addr,
    output logic                 I_RW,
    output logic                 I_En,
    output logic                 O_RW,
    output logic                 O_En,
    output logic                 Done,
    output logic [D_WIDTH-1:0]   Surf_Out
);
    localparam int LW = $clog2(MAXBOX + 2);
    localparam int BW = (MAXBOX > 1) ? $clog2(MAXBOX) : 1;
    localparam int RW = 24;
    localparam int DW = 48;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_ACC, S_DET, S_WRITE, S_DONE
    } state_t;

    state_t               state_q;
    logic [LW-1:0]        ld_q, b_q;
    logic [1:0]           f_q, k_q;
    logic [A_WIDTH-1:0]   row_q, col_q, wr_addr_q;
    logic [A_WIDTH-1:0]   i_addr_q, d_addr_q;
    logic [XA_WIDTH-1:0]  x_addr_q;
    logic [XYA_WIDTH-1:0] xy_addr_q;
    logic                 i_en_q, o_en_q, done_q;
    logic [D_WIDTH-1:0]   surf_q;
    logic                 vld_p0, vld_p1;

    logic [LW-1:0]         cnt_q [3];
    logic [RD_WIDTH-1:0]   dsc_q [3][MAXBOX];
    logic [LW-1:0]         idx_p0, idx_p1;
    logic [1:0]            f_p0, f_p1, k_p0, k_p1;
    logic signed [3:0]     w_p0, w_p1;
    logic [D_WIDTH-1:0]    box_q;
    logic signed [RW-1:0]  resp_q [3];

    logic                 issue_load, issue_fetch, last_win;
    logic [RD_WIDTH-1:0]  cur;
    logic [6:0]           ofs_r, ofs_c;
    logic [A_WIDTH-1:0]   i_addr_d;
    logic [D_WIDTH-1:0]   box_d;
    logic signed [RW-1:0] prod_d;
    logic [BW-1:0]        li;

    function automatic logic [LW-1:0] clamp_cnt(input logic [3:0] n);
        return (int'(n) > MAXBOX) ? LW'(MAXBOX) : LW'(n);
    endfunction

    function automatic logic signed [DW-1:0] hess(input logic signed [RW-1:0] xx,
                                                   input logic signed [RW-1:0] yy,
                                                   input logic signed [RW-1:0] xy);
        logic signed [DW-1:0] a, b, c;
        a = DW'(xx);
        b = DW'(yy);
        c = DW'(xy);
        return a * b - ((c * c * DW'(13)) >>> 4);
    endfunction

    function automatic logic [D_WIDTH-1:0] sat(input logic signed [DW-1:0] v);
        logic signed [DW-1:0] s;
        s = v >>> DET_SHIFT;
        if (s < 0) return '0;
        if (s[DW-1:D_WIDTH] != '0) return '1;
        return s[D_WIDTH-1:0];
    endfunction

    always_comb begin
        issue_load  = (state_q == S_LOAD) && (int'(ld_q) <= MAXBOX);
        cur         = dsc_q[f_q][b_q[BW-1:0]];
        issue_fetch = (state_q == S_FETCH) && (b_q < cnt_q[f_q]);
        // corner order per box: (r1,c1)+ (r0,c1)- (r1,c0)- (r0,c0)+
        ofs_r       = k_q[0] ? cur[27:21] : cur[13:7];
        ofs_c       = k_q[1] ? cur[20:14] : cur[6:0];
        i_addr_d    = (row_q + A_WIDTH'(ofs_r)) * A_WIDTH'(COL) + col_q + A_WIDTH'(ofs_c);
        box_d       = (k_p1 == 2'd0) ? I_Data :
                      ((k_p1[0] ^ k_p1[1]) ? box_q - I_Data : box_q + I_Data);
        prod_d      = $signed({{(RW-4){w_p1[3]}}, w_p1}) * $signed({{(RW-D_WIDTH){1'b0}}, box_d});
        li          = BW'(idx_p1 - 1'b1);
        last_win    = (row_q == A_WIDTH'(ROW - FS)) && (col_q == A_WIDTH'(COL - FS));
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            ld_q      <= '0;
            b_q       <= '0;
            f_q       <= '0;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            wr_addr_q <= '0;
            i_addr_q  <= '0;
            d_addr_q  <= '0;
            x_addr_q  <= '0;
            xy_addr_q <= '0;
            i_en_q    <= 1'b0;
            o_en_q    <= 1'b0;
            done_q    <= 1'b0;
            surf_q    <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            // p0: address presented to memories; p1: read data returned
            i_en_q <= issue_load || issue_fetch;
            vld_p0 <= issue_load || issue_fetch;
            vld_p1 <= vld_p0;
            o_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Go) begin
                        state_q   <= S_LOAD;
                        ld_q      <= '0;
                        row_q     <= '0;
                        col_q     <= '0;
                        wr_addr_q <= '0;
                        done_q    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (issue_load) begin
                        x_addr_q  <= XA_WIDTH'(ld_q);
                        xy_addr_q <= XYA_WIDTH'(ld_q);
                        ld_q      <= ld_q + 1'b1;
                    end else if (!vld_p0 && !vld_p1) begin
                        state_q <= S_FETCH;
                        f_q     <= '0;
                        b_q     <= '0;
                        k_q     <= '0;
                    end
                end
                S_FETCH: begin
                    if (issue_fetch) begin
                        i_addr_q <= i_addr_d;
                        k_q      <= k_q + 1'b1;
                        if (k_q == 2'd3) b_q <= b_q + 1'b1;
                    end else begin
                        b_q <= '0;
                        k_q <= '0;
                        if (f_q == 2'd2) state_q <= S_ACC;
                        else             f_q     <= f_q + 1'b1;
                    end
                end
                S_ACC: begin
                    if (!vld_p0 && !vld_p1) state_q <= S_DET;
                end
                S_DET: begin
                    surf_q   <= sat(hess(resp_q[0], resp_q[1], resp_q[2]));
                    d_addr_q <= wr_addr_q;
                    o_en_q   <= 1'b1;
                    state_q  <= S_WRITE;
                end
                S_WRITE: begin
                    wr_addr_q <= wr_addr_q + 1'b1;
                    if (last_win) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        if (col_q == A_WIDTH'(COL - FS)) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        f_q     <= '0;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (issue_load) idx_p0 <= ld_q;
        if (issue_fetch) begin
            f_p0 <= f_q;
            k_p0 <= k_q;
            w_p0 <= cur[31:28];
        end
        idx_p1 <= idx_p0;
        f_p1   <= f_p0;
        k_p1   <= k_p0;
        w_p1   <= w_p0;
        if (vld_p1 && state_q == S_LOAD) begin
            if (idx_p1 == '0) begin
                cnt_q[0] <= clamp_cnt(X_Data[3:0]);
                cnt_q[1] <= clamp_cnt(Y_Data[3:0]);
                cnt_q[2] <= clamp_cnt(XY_Data[3:0]);
            end else begin
                dsc_q[0][li] <= X_Data;
                dsc_q[1][li] <= Y_Data;
                dsc_q[2][li] <= XY_Data;
            end
        end
        // responses restart at every window; box sum is carried modulo 2^D_WIDTH
        if (state_q == S_LOAD || state_q == S_WRITE) begin
            for (int i = 0; i < 3; i++) resp_q[i] <= '0;
        end else if (vld_p1) begin
            box_q <= box_d;
            if (k_p1 == 2'd3) resp_q[f_p1] <= resp_q[f_p1] + prod_d;
        end
    end

    assign I_Addr   = i_addr_q;
    assign X_Addr   = x_addr_q;
    assign Y_Addr   = x_addr_q;
    assign XY_Addr  = xy_addr_q;
    assign D_Addr   = d_addr_q;
    assign I_RW     = 1'b1;
    assign I_En     = i_en_q;
    assign O_RW     = ~o_en_q;
    assign O_En     = o_en_q;
    assign Done     = done_q;
    assign Surf_Out = surf_q;

endmodule

// File: tb/tb_calc_determinant.sv
// Bench for calc_determinant on a reduced image: external memories, write capture
// and a window-level reference model of the determinant.
module tb_calc_determinant;
    localparam int COL = 16, ROW = 12, FS = 9, MAXBOX = 4, SHIFT = 0, AW = 17;
    localparam int NWC = COL - FS + 1, NWR = ROW - FS + 1, NW = NWC * NWR;
    localparam int LIMIT = 6000;

    logic clk;
    logic rst, go;
    logic [AW-1:0] i_addr, d_addr;
    logic [15:0] i_data, surf;
    logic [3:0] x_addr, y_addr;
    logic [4:0] xy_addr;
    logic [31:0] x_data, y_data, xy_data;
    logic i_rw, i_en, o_rw, o_en, done;

    logic [15:0] img [COL*ROW];
    logic [31:0] xrf [16];
    logic [31:0] yrf [16];
    logic [31:0] xyrf [32];

    logic [AW-1:0] qa [$];
    logic [15:0]   qd [$];

    int n_chk = 0;
    int n_fail = 0;

    calc_determinant #(
        .A_WIDTH(AW), .D_WIDTH(16), .COL(COL), .ROW(ROW), .FS(FS), .XA_WIDTH(4),
        .XYA_WIDTH(5), .RD_WIDTH(32), .MAXBOX(MAXBOX), .DET_SHIFT(SHIFT)
    ) dut (
        .Clk(clk), .Rst(rst), .Go(go),
        .I_Addr(i_addr), .I_Data(i_data),
        .X_Addr(x_addr), .X_Data(x_data),
        .Y_Addr(y_addr), .Y_Data(y_data),
        .XY_Addr(xy_addr), .XY_Data(xy_data),
        .D_Addr(d_addr), .I_RW(i_rw), .I_En(i_en), .O_RW(o_rw), .O_En(o_en),
        .Done(done), .Surf_Out(surf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (i_en && i_rw) begin
            i_data  <= (int'(i_addr) < COL * ROW) ? img[int'(i_addr)] : 16'h0;
            x_data  <= xrf[x_addr];
            y_data  <= yrf[y_addr];
            xy_data <= xyrf[xy_addr];
        end
    end

    always @(negedge clk) begin
        if (o_en === 1'b1 && o_rw === 1'b0) begin
            qa.push_back(d_addr);
            qd.push_back(surf);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int w, input int r0, input int c0, input int r1, input int c1);
        logic [31:0] v;
        v[31:28] = 4'(w);
        v[27:21] = 7'(r0);
        v[20:14] = 7'(c0);
        v[13:7]  = 7'(r1);
        v[6:0]   = 7'(c1);
        return v;
    endfunction

    function automatic logic [31:0] rf_word(input int f, input int a);
        if (f == 0) return xrf[a];
        if (f == 1) return yrf[a];
        return xyrf[a];
    endfunction

    function automatic int ii(input int r, input int c);
        return int'(img[r * COL + c]);
    endfunction

    // sum of w*S over the filter's boxes, S taken modulo 2^16 as an unsigned value
    function automatic longint resp(input int f, input int R, input int C);
        logic [31:0] w;
        int n, s, wt, r0, c0, r1, c1;
        longint acc;
        w = rf_word(f, 0);
        n = int'(w[3:0]);
        if (n > MAXBOX) n = MAXBOX;
        acc = 0;
        for (int b = 1; b <= n; b++) begin
            w  = rf_word(f, b);
            wt = int'($signed(w[31:28]));
            r0 = int'(w[27:21]);
            c0 = int'(w[20:14]);
            r1 = int'(w[13:7]);
            c1 = int'(w[6:0]);
            s  = (ii(R + r1, C + c1) - ii(R + r0, C + c1) - ii(R + r1, C + c0) + ii(R + r0, C + c0)) & 32'hFFFF;
            acc += longint'(wt) * longint'(s);
        end
        return acc;
    endfunction

    function automatic longint expect_out(input int i);
        int R, C;
        longint xx, yy, xy, det;
        R = i / NWC;
        C = i % NWC;
        xx = resp(0, R, C);
        yy = resp(1, R, C);
        xy = resp(2, R, C);
        det = xx * yy - ((13 * xy * xy) >>> 4);
        det = det >>> SHIFT;
        if (det < 0) return 0;
        if (det > 65535) return 65535;
        return det;
    endfunction

    task automatic clear_rf();
        for (int a = 0; a < 16; a++) begin
            xrf[a] = '0;
            yrf[a] = '0;
        end
        for (int a = 0; a < 32; a++) xyrf[a] = '0;
    endtask

    task automatic fill_ones();
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) img[r * COL + c] = 16'((r + 1) * (c + 1));
    endtask

    task automatic fill_raw();
        for (int a = 0; a < COL * ROW; a++) img[a] = 16'($urandom);
    endtask

    task automatic fill_cum();
        int up, left, ul, p;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) begin
                p    = int'($urandom_range(0, 3));
                up   = (r > 0) ? ii(r - 1, c) : 0;
                left = (c > 0) ? ii(r, c - 1) : 0;
                ul   = (r > 0 && c > 0) ? ii(r - 1, c - 1) : 0;
                img[r * COL + c] = 16'(p + up + left - ul);
            end
    endtask

    function automatic logic [31:0] rand_desc();
        return mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                  int'($urandom_range(0, 8)), int'($urandom_range(0, 8)));
    endfunction

    task automatic rand_rf();
        for (int a = 1; a < 16; a++) begin
            xrf[a] = rand_desc();
            yrf[a] = rand_desc();
        end
        for (int a = 1; a < 32; a++) xyrf[a] = rand_desc();
        xrf[0]  = $urandom;
        yrf[0]  = $urandom;
        xyrf[0] = $urandom;
    endtask

    task automatic run_scan(input string tag, input bit go_mid);
        int cyc;
        qa.delete();
        qd.delete();
        go = 1'b1;
        tick();
        go = 1'b0;
        check({tag, "_done_clr"}, 64'(done), 64'(0));
        cyc = 0;
        while (done !== 1'b1 && cyc < LIMIT) begin
            go = go_mid && (cyc == 300);
            tick();
            cyc++;
        end
        go = 1'b0;
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_nwrites"}, 64'(qa.size()), 64'(NW));
        for (int i = 0; i < qa.size() && i < NW; i++) begin
            check({tag, "_addr"}, 64'(qa[i]), 64'(i));
            check({tag, "_data"}, 64'(qd[i]), 64'(expect_out(i)));
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        go  = 1'b0;
        fill_ones();
        clear_rf();
        repeat (3) tick();
        check("rst_o_en", 64'(o_en), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_i_en", 64'(i_en), 64'(0));
        check("rst_i_rw", 64'(i_rw), 64'(1));
        check("rst_o_rw", 64'(o_rw), 64'(1));
        check("rst_surf", 64'(surf), 64'(0));
        check("rst_d_addr", 64'(d_addr), 64'(0));
        rst = 1'b0;
        tick();

        // balanced filters on an all-ones image cancel to zero
        xrf[0] = 32'd3;
        xrf[1] = mk(1, 0, 0, 3, 3);
        xrf[2] = mk(-2, 3, 0, 6, 3);
        xrf[3] = mk(1, 5, 5, 8, 8);
        for (int a = 0; a < 4; a++) yrf[a] = xrf[a];
        xyrf[0] = 32'd4;
        xyrf[1] = mk(1, 0, 0, 3, 3);
        xyrf[2] = mk(-1, 0, 3, 3, 6);
        xyrf[3] = mk(-1, 3, 0, 6, 3);
        xyrf[4] = mk(1, 3, 3, 6, 6);
        run_scan("zero", 1'b0);
        if (qd.size() == NW) check("zero_const", 64'(qd[NW-1]), 64'(0));

        clear_rf();
        xrf[0] = 32'd1;
        xrf[1] = mk(1, 0, 0, 3, 3);
        yrf[0] = 32'd1;
        yrf[1] = mk(1, 0, 0, 3, 3);
        run_scan("b81", 1'b0);
        if (qd.size() > 0) check("b81_const", 64'(qd[0]), 64'(81));

        xrf[1] = mk(-1, 0, 0, 3, 3);
        run_scan("neg", 1'b1);
        if (qd.size() > 0) check("neg_const", 64'(qd[0]), 64'(0));

        xrf[1] = mk(7, 0, 0, 8, 8);
        yrf[1] = mk(7, 0, 0, 8, 8);
        run_scan("sat", 1'b0);
        if (qd.size() > 0) check("sat_const", 64'(qd[0]), 64'(65535));
        repeat (5) tick();
        check("done_held", 64'(done), 64'(1));
        check("done_nowrite", 64'(qa.size()), 64'(NW));

        fill_raw();
        rand_rf();
        run_scan("rnd_raw", 1'b0);
        fill_cum();
        rand_rf();
        run_scan("rnd_cum", 1'b1);
        rand_rf();
        run_scan("rnd_cum2", 1'b0);

        qa.delete();
        qd.delete();
        go = 1'b1;
        tick();
        go = 1'b0;
        cyc = 0;
        while (qa.size() < 10 && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        check("rst_mid_reach", 64'(qa.size()), 64'(10));
        rst = 1'b1;
        tick();
        check("rst_mid_o_en", 64'(o_en), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        rst = 1'b0;
        repeat (40) tick();
        check("rst_mid_nowrite", 64'(qa.size()), 64'(10));
        check("rst_mid_idle_done", 64'(done), 64'(0));
        run_scan("after_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
